// File: rtl/harness_reset_pkg.sv
// Shared reset-sequencing types and default timing constants for the harness.
// The sequencer FSM states and counter sizing helpers live here.
package harness_reset_pkg;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        DEBOUNCE,
        HOLD,
        RUN
    } seq_state_t;

    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_PLL_RST_CYCLES = 16;
    localparam int DEF_LOCK_CYCLES    = 1024;
    localparam int DEF_HOLD_CYCLES    = 64;
    localparam int DEF_TIMEOUT_CYCLES = 1048576;

    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // A count of N cycles needs to reach N-1, so $clog2(N) bits suffice.
    function automatic int cnt_width(input int max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Signals between the PLL/core side of the harness and the reset sequencer.
// master = harness side (provides lock), slave = sequencer.
interface pll_reset_sequencer_if;

    logic       pll_locked;
    logic       pll_rst;
    logic       core_reset;
    logic       running;
    logic [7:0] restart_count;

    modport master (
        output pll_locked,
        input  pll_rst,
        input  core_reset,
        input  running,
        input  restart_count
    );

    modport slave (
        input  pll_locked,
        output pll_rst,
        output core_reset,
        output running,
        output restart_count
    );

endinterface

// File: rtl/sync_bit.sv
// Generic N-stage single-bit synchronizer with asynchronous reset.
// STAGES must be at least 2.
module sync_bit #(
    parameter int   STAGES      = 2,
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= {STAGES{RESET_VALUE}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Sequences the PLL reset, qualifies pll_locked (sync + debounce) and holds the
// core in reset until lock has been stable for a while; restarts the PLL on timeout.
module pll_reset_sequencer
    import harness_reset_pkg::*;
#(
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int LOCK_CYCLES    = DEF_LOCK_CYCLES,
    parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  sys_clock,
    input  logic                  reset,
    pll_reset_sequencer_if.slave  bus
);

    localparam int MAX_COUNT = max_of4(PLL_RST_CYCLES, LOCK_CYCLES, HOLD_CYCLES, TIMEOUT_CYCLES);
    localparam int CW        = cnt_width(MAX_COUNT);

    localparam logic [CW-1:0] PLL_RST_LAST = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] LOCK_LAST    = CW'(LOCK_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic        w_lock_s;
    seq_state_t  r_state;
    seq_state_t  w_state_next;
    logic [CW-1:0] r_count;
    logic        w_timeout;
    logic        w_pll_rst_next;
    logic        w_core_reset_next;
    logic        w_running_next;
    logic        r_pll_rst;
    logic        r_core_reset;
    logic        r_running;
    logic [7:0]  r_restart_count;

    sync_bit #(
        .STAGES      (SYNC_STAGES),
        .RESET_VALUE (1'b0)
    ) u_lock_sync (
        .clk (sys_clock),
        .rst (reset),
        .i_d (bus.pll_locked),
        .o_q (w_lock_s)
    );

    // Lock drops win over terminal counts; a present lock wins over timeout.
    always_comb begin
        w_state_next = r_state;
        w_timeout    = 1'b0;
        case (r_state)
            PLL_RST: begin
                if (r_count == PLL_RST_LAST) w_state_next = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (w_lock_s) begin
                    w_state_next = DEBOUNCE;
                end else if (r_count == TIMEOUT_LAST) begin
                    w_state_next = PLL_RST;
                    w_timeout    = 1'b1;
                end
            end
            DEBOUNCE: begin
                if (!w_lock_s) w_state_next = WAIT_LOCK;
                else if (r_count == LOCK_LAST) w_state_next = HOLD;
            end
            HOLD: begin
                if (!w_lock_s) w_state_next = WAIT_LOCK;
                else if (r_count == HOLD_LAST) w_state_next = RUN;
            end
            RUN: begin
                if (!w_lock_s) w_state_next = WAIT_LOCK;
            end
            default: begin
                w_state_next = PLL_RST;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_comb begin
        w_pll_rst_next    = (w_state_next == PLL_RST);
        w_core_reset_next = (w_state_next != RUN);
        w_running_next    = (w_state_next == RUN);
    end

    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            r_state <= PLL_RST;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_state_next != r_state) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            r_pll_rst       <= 1'b1;
            r_core_reset    <= 1'b1;
            r_running       <= 1'b0;
            r_restart_count <= 8'd0;
        end else begin
            r_pll_rst    <= w_pll_rst_next;
            r_core_reset <= w_core_reset_next;
            r_running    <= w_running_next;
            if (w_timeout && (r_restart_count != 8'hFF)) begin
                r_restart_count <= r_restart_count + 8'd1;
            end
        end
    end

    assign bus.pll_rst       = r_pll_rst;
    assign bus.core_reset    = r_core_reset;
    assign bus.running       = r_running;
    assign bus.restart_count = r_restart_count;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer with small timing parameters.
// Expected output words are queued per edge number and checked on the falling edge.
module tb_pll_reset_sequencer;

    logic sys_clock = 1'b0;
    logic reset     = 1'b1;
    int   cyc       = 0;
    int   n_checks  = 0;
    int   n_pass    = 0;

    typedef struct {
        string       tag;
        int          edge_no;
        logic [10:0] val;
    } exp_t;

    exp_t sb[$];
    exp_t head;

    pll_reset_sequencer_if bus();

    pll_reset_sequencer #(
        .SYNC_STAGES    (2),
        .PLL_RST_CYCLES (4),
        .LOCK_CYCLES    (8),
        .HOLD_CYCLES    (4),
        .TIMEOUT_CYCLES (32)
    ) dut (
        .sys_clock (sys_clock),
        .reset     (reset),
        .bus       (bus.slave)
    );

    always #5 sys_clock = ~sys_clock;

    // Edge numbering: edge 1 is the first rising edge after reset deasserts.
    always @(posedge sys_clock) begin
        if (reset) cyc = 0;
        else       cyc = cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Word layout: {pll_rst, core_reset, running, restart_count[7:0]}
    always @(negedge sys_clock) begin
        if (!reset) begin
            while (sb.size() > 0 && sb[0].edge_no <= cyc) begin
                head = sb.pop_front();
                chk(head.tag,
                    {21'd0, bus.pll_rst, bus.core_reset, bus.running, bus.restart_count},
                    {21'd0, head.val});
            end
        end
    end

    task automatic expect_at(input int e, input string tag, input logic pr, input logic cr,
                             input logic rn, input logic [7:0] rc);
        exp_t x;
        x.tag     = tag;
        x.edge_no = e;
        x.val     = {pr, cr, rn, rc};
        sb.push_back(x);
    endtask

    task automatic at_edge(input int k);
        while (cyc < k) begin
            @(posedge sys_clock);
            #1;
        end
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && sb.size() > 0; i++) @(posedge sys_clock);
        #1;
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge sys_clock);
        #1;
        chk("rst_pll_rst",    {31'd0, bus.pll_rst},    1);
        chk("rst_core_reset", {31'd0, bus.core_reset}, 1);
        chk("rst_running",    {31'd0, bus.running},    0);
        chk("rst_restart",    {24'd0, bus.restart_count}, 0);
        @(negedge sys_clock);
        reset = 1'b0;
    endtask

    initial begin
        bus.pll_locked = 1'b1;

        // Lock already present, then a lock loss in RUN and re-lock.
        do_reset();
        expect_at(3,   "s1_prst_hi", 1, 1, 0, 0);
        expect_at(4,   "s1_prst_lo", 0, 1, 0, 0);
        expect_at(16,  "s1_hold",    0, 1, 0, 0);
        expect_at(17,  "s1_run",     0, 0, 1, 0);
        expect_at(100, "s4_run",     0, 0, 1, 0);
        expect_at(102, "s4_latency", 0, 0, 1, 0);
        expect_at(103, "s4_drop",    0, 1, 0, 0);
        expect_at(124, "s4_relock",  0, 1, 0, 0);
        expect_at(125, "s4_rerun",   0, 0, 1, 0);
        at_edge(100);
        bus.pll_locked = 1'b0;
        at_edge(110);
        bus.pll_locked = 1'b1;
        wait_drain(200);

        // Toggling lock (period 6) never qualifies, then steady lock.
        bus.pll_locked = 1'b1;
        do_reset();
        expect_at(10, "s3_tog10", 0, 1, 0, 0);
        expect_at(20, "s3_tog20", 0, 1, 0, 0);
        expect_at(30, "s3_tog30", 0, 1, 0, 0);
        expect_at(44, "s3_hold",  0, 1, 0, 0);
        expect_at(45, "s3_run",   0, 0, 1, 0);
        for (int k = 1; k < 30; k++) begin
            at_edge(k);
            bus.pll_locked = ((k % 6) < 3);
        end
        at_edge(30);
        bus.pll_locked = 1'b1;
        wait_drain(100);

        // Asynchronous reset while in HOLD, then a full restart.
        bus.pll_locked = 1'b1;
        do_reset();
        expect_at(13, "s5_in_hold", 0, 1, 0, 0);
        at_edge(14);
        #1;
        reset = 1'b1;
        #1;
        chk("s5_async_pll_rst",    {31'd0, bus.pll_rst},    1);
        chk("s5_async_core_reset", {31'd0, bus.core_reset}, 1);
        chk("s5_async_running",    {31'd0, bus.running},    0);
        do_reset();
        expect_at(4,  "s5_prst_lo", 0, 1, 0, 0);
        expect_at(16, "s5_hold",    0, 1, 0, 0);
        expect_at(17, "s5_run",     0, 0, 1, 0);
        wait_drain(100);

        // No lock: periodic PLL restarts with a saturating restart count.
        bus.pll_locked = 1'b0;
        do_reset();
        expect_at(35,   "s2_wait_end", 0, 1, 0, 0);
        expect_at(36,   "s2_restart1", 1, 1, 0, 1);
        expect_at(39,   "s2_prst_end", 1, 1, 0, 1);
        expect_at(40,   "s2_wait1",    0, 1, 0, 1);
        expect_at(71,   "s2_wait1_end",0, 1, 0, 1);
        expect_at(72,   "s2_restart2", 1, 1, 0, 2);
        expect_at(108,  "s2_restart3", 1, 1, 0, 3);
        expect_at(9179, "s6_cnt254",   0, 1, 0, 254);
        expect_at(9180, "s6_cnt255",   1, 1, 0, 255);
        expect_at(9215, "s6_pre_sat",  0, 1, 0, 255);
        expect_at(9216, "s6_sat",      1, 1, 0, 255);
        expect_at(9220, "s6_sat_wait", 0, 1, 0, 255);
        wait_drain(10000);

        // Reset must clear the saturated count.
        do_reset();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Reset sequencer between the harness system PLL and the SoC core. It runs on the free-running board clock and sequences the PLL's own reset. It then qualifies `pll_locked` with a synchronizer and a debounce window, and holds the core in reset for a fixed time after a stable lock. Core reset asserts again whenever lock is lost, and the PLL is restarted if lock never arrives. In the harness top it replaces the direct `!pll_locked` core reset.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flops in the `pll_locked` synchronizer; must be ≥ 2.
- `PLL_RST_CYCLES`, 16: cycles `pll_rst` is held high per PLL restart; must be ≥ 1.
- `LOCK_CYCLES`, 1024: consecutive cycles the synchronized lock must stay high before it is accepted.
- `HOLD_CYCLES`, 64: cycles `core_reset` stays high after lock is accepted.
- `TIMEOUT_CYCLES`, 1048576: cycles to wait for lock before restarting the PLL.

Ports:
- `sys_clock`  in  1: board clock, free-running. This is the single clock of the block.
- `reset`  in  1: asynchronous, active-high.
- `pll_locked`  in  1: PLL lock status, asynchronous to `sys_clock`.
- `pll_rst`  out  1: reset to the PLL `pll_rst` pin.
- `core_reset`  out  1: active-high reset for the core.
- `running`  out  1: high only in state RUN.
- `restart_count`  out  8: number of PLL restarts caused by lock timeout; saturates at 255.

## Operation
- All outputs are registered.
- Reset values: state PLL_RST, `pll_rst`=1, `core_reset`=1, `running`=0, `restart_count`=0, counter=0, synchronizer flops=0.
- `pll_locked` passes through `SYNC_STAGES` flops to produce `lock_s`. The FSM uses only `lock_s`.
- A single cycle counter is shared by all states. It clears on every state transition and increments every cycle otherwise. Its width is `$clog2` of the largest count.

FSM states and transitions:
- PLL_RST: `pll_rst`=1. When counter == `PLL_RST_CYCLES`-1, go to WAIT_LOCK.
- WAIT_LOCK: `pll_rst`=0.
  - If `lock_s`=1, go to DEBOUNCE.
  - Otherwise, when counter == `TIMEOUT_CYCLES`-1, go to PLL_RST and increment `restart_count` (saturating).
- DEBOUNCE:
  - If `lock_s`=0, go to WAIT_LOCK.
  - Otherwise, when counter == `LOCK_CYCLES`-1, go to HOLD.
- HOLD:
  - If `lock_s`=0, go to WAIT_LOCK.
  - Otherwise, when counter == `HOLD_CYCLES`-1, go to RUN.
- RUN: `core_reset`=0 and `running`=1. If `lock_s`=0, go to WAIT_LOCK.

Output and priority rules:
- `core_reset` is 1 in every state except RUN.
- In DEBOUNCE and HOLD, a lock drop takes priority over a terminal count reached in the same cycle.
- In WAIT_LOCK, `lock_s`=1 takes priority over timeout.
- A mid-operation `reset` asserts all outputs to their reset values immediately, without waiting for a clock edge. Sequencing restarts from PLL_RST.

## Timing
- Edge 1 is the first `sys_clock` rising edge after `reset` deasserts.
- Case: `pll_locked` is already high and the default parameters are used.
  - `pll_rst` falls at edge `PLL_RST_CYCLES` (16).
  - WAIT_LOCK lasts 1 cycle.
  - `core_reset` falls and `running` rises at edge `PLL_RST_CYCLES`+1+`LOCK_CYCLES`+`HOLD_CYCLES` (1105).
- Lock-loss response:
  - A `pll_locked` fall in RUN raises `core_reset` at edge `SYNC_STAGES`+1 after the fall.
  - This assumes the fall is set up before an edge.
- A lock glitch shorter than one cycle may be missed by the synchronizer; this is acceptable.
- Any lock drop seen during DEBOUNCE restarts the full `LOCK_CYCLES` window.
- `core_reset` is synchronous to `sys_clock`. Its deassertion is re-synchronized into the PLL clock domain by a reset synchronizer in the harness top, which is not part of this block.

## Structure
- Shared package `harness_reset_pkg` holds:
  - the state enum `seq_state_t` (PLL_RST, WAIT_LOCK, DEBOUNCE, HOLD, RUN);
  - the default parameter constants.
- One sub-module: `sync_bit`, a generic N-stage synchronizer with asynchronous reset. It is used for `pll_locked` and is reusable elsewhere in the harness.

## Test plan
All scenarios use `PLL_RST_CYCLES`=4, `LOCK_CYCLES`=8, `HOLD_CYCLES`=4, `TIMEOUT_CYCLES`=32, `SYNC_STAGES`=2.
1. `pll_locked` tied to 1, release `reset` → `pll_rst` falls at edge 4; `core_reset` falls and `running` rises at edge 17; `restart_count` stays 0.
2. `pll_locked` held at 0 → `pll_rst` re-pulses for 4 cycles every 36 cycles; `restart_count` increments 1, 2, 3, ….
3. `pll_locked` toggles with period 6 cycles, then goes high permanently → `core_reset` stays high while toggling and falls exactly 13 cycles after `lock_s` settles high.
4. In RUN, drop `pll_locked` at edge 100 → `core_reset` rises at edge 103. Re-raise the lock → `core_reset` falls 13 cycles after `lock_s` rises.
5. Assert `reset` asynchronously while in HOLD → `core_reset`=1, `pll_rst`=1 and `running`=0 before the next edge; full sequence restarts.
6. Force `restart_count` to 255 via 255 timeouts, then one more timeout → `restart_count` stays at 255.
